// File: rtl/pipe_pkg.sv
// Shared widths and types for the 16-bit, 8-register pipeline.
//   DATA_W       register width
//   ADDR_W       register index width, NREGS = 2**ADDR_W
//   MAX_INFLIGHT outstanding writes tracked per register
//   CNT_W        width of a per-register in-flight counter
package pipe_pkg;

    localparam int unsigned DATA_W       = 16;
    localparam int unsigned ADDR_W       = 3;
    localparam int unsigned NREGS        = 2 ** ADDR_W;
    localparam int unsigned MAX_INFLIGHT = 3;
    localparam int unsigned CNT_W        = $clog2(MAX_INFLIGHT + 1);

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;
    typedef logic [CNT_W-1:0]  cnt_t;

endpackage : pipe_pkg

// File: rtl/sb_counter.sv
// In-flight write counter for one architectural register.
//   clk, rst  clock, async active-high reset
//   inc       an instruction writing this register was accepted
//   dec       a writeback to this register arrived (ignored when count is 0)
//   cnt       current outstanding-write count
//   at_max    count equals MAX_INFLIGHT
//   nonzero   at least one write outstanding
module sb_counter
    import pipe_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output cnt_t cnt,
    output logic at_max,
    output logic nonzero
);

    logic dec_eff;

    assign nonzero = (cnt != '0);
    assign at_max  = (cnt == CNT_W'(MAX_INFLIGHT));
    // A writeback with nothing outstanding must not underflow.
    assign dec_eff = dec && nonzero;

    // Up/down count; simultaneous inc and dec cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && !dec_eff && !at_max) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec_eff && !inc) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule : sb_counter

// File: rtl/reg_file_scoreboard.sv
// Architectural register file with writeback bypass and a per-register
// in-flight write scoreboard that stalls issue on pending sources or on a
// saturated destination counter.
//   clk, rst                 clock, async active-high reset
//   wb_en/wb_dest/wb_data    writeback port
//   rd_addr_a/b, rd_data_a/b combinational read ports with bypass
//   issue_valid, issue_wr, issue_dest, src_a_used, src_b_used  issue request
//   stall                    issue blocked this cycle (combinational)
//   busy_vec                 bit r set while register r has writes outstanding
//   sb_err                   sticky: writeback without a matching issue
module reg_file_scoreboard
    import pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_en,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic             issue_valid,
    input  logic             issue_wr,
    input  logic [ADDR_W-1:0] issue_dest,
    input  logic             src_a_used,
    input  logic             src_b_used,
    output logic             stall,
    output logic [NREGS-1:0] busy_vec,
    output logic             sb_err
);

    word_t                        regs [NREGS];
    logic [NREGS-1:0][CNT_W-1:0]  cnt_vec;
    logic [NREGS-1:0]             nonzero_vec;
    logic [NREGS-1:0]             at_max_vec;
    logic [NREGS-1:0]             busy_c;
    logic                         accept;
    logic                         wb_valid;

    // r0 is hardwired zero, so writebacks to it are dropped entirely.
    assign wb_valid = wb_en && (wb_dest != '0);

    // Per-register counters; r0 is never scoreboarded.
    for (genvar r = 0; r < NREGS; r++) begin : g_sb
        if (r == 0) begin : g_r0
            assign cnt_vec[r]     = '0;
            assign nonzero_vec[r] = 1'b0;
            assign at_max_vec[r]  = 1'b0;
            assign busy_c[r]      = 1'b0;
        end else begin : g_rn
            logic inc;
            logic dec;
            logic wb_hit;

            assign wb_hit = wb_en && (wb_dest == reg_idx_t'(r));
            assign inc    = accept && issue_wr && (issue_dest == reg_idx_t'(r));
            assign dec    = wb_hit;

            sb_counter u_cnt (
                .clk     (clk),
                .rst     (rst),
                .inc     (inc),
                .dec     (dec),
                .cnt     (cnt_vec[r]),
                .at_max  (at_max_vec[r]),
                .nonzero (nonzero_vec[r])
            );

            // The last outstanding write completing this cycle is covered by the bypass.
            assign busy_c[r] = nonzero_vec[r] &&
                               !((cnt_vec[r] == CNT_W'(1)) && wb_hit);
        end
    end

    assign busy_vec = nonzero_vec;

    // Issue hazard check: pending sources or a full destination counter
    // that is not draining this cycle.
    always_comb begin
        stall = 1'b0;
        if (issue_valid) begin
            if (src_a_used && busy_c[rd_addr_a]) begin
                stall = 1'b1;
            end
            if (src_b_used && busy_c[rd_addr_b]) begin
                stall = 1'b1;
            end
            if (issue_wr && (issue_dest != '0) && at_max_vec[issue_dest] &&
                !(wb_en && (wb_dest == issue_dest))) begin
                stall = 1'b1;
            end
        end
    end

    assign accept = issue_valid && !stall;

    // Read port A with write-through bypass.
    always_comb begin
        rd_data_a = '0;
        if (rd_addr_a != '0) begin
            if (wb_en && (wb_dest == rd_addr_a)) begin
                rd_data_a = wb_data;
            end else begin
                rd_data_a = regs[rd_addr_a];
            end
        end
    end

    // Read port B with write-through bypass.
    always_comb begin
        rd_data_b = '0;
        if (rd_addr_b != '0) begin
            if (wb_en && (wb_dest == rd_addr_b)) begin
                rd_data_b = wb_data;
            end else begin
                rd_data_b = regs[rd_addr_b];
            end
        end
    end

    // Register array write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_valid) begin
            regs[wb_dest] <= wb_data;
        end
    end

    // Sticky flag for a writeback that no accepted issue accounts for.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_err <= 1'b0;
        end else if (wb_valid && !nonzero_vec[wb_dest]) begin
            sb_err <= 1'b1;
        end
    end

endmodule : reg_file_scoreboard

// File: tb/tb_reg_file_scoreboard.sv
module tb_reg_file_scoreboard;

    logic        clk;
    logic        rst;
    logic        wb_en;
    logic [2:0]  wb_dest;
    logic [15:0] wb_data;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic        issue_valid;
    logic        issue_wr;
    logic [2:0]  issue_dest;
    logic        src_a_used;
    logic        src_b_used;
    logic        stall;
    logic [7:0]  busy_vec;
    logic        sb_err;

    int total;
    int bad;

    reg_file_scoreboard dut (
        .clk         (clk),
        .rst         (rst),
        .wb_en       (wb_en),
        .wb_dest     (wb_dest),
        .wb_data     (wb_data),
        .rd_addr_a   (rd_addr_a),
        .rd_addr_b   (rd_addr_b),
        .rd_data_a   (rd_data_a),
        .rd_data_b   (rd_data_b),
        .issue_valid (issue_valid),
        .issue_wr    (issue_wr),
        .issue_dest  (issue_dest),
        .src_a_used  (src_a_used),
        .src_b_used  (src_b_used),
        .stall       (stall),
        .busy_vec    (busy_vec),
        .sb_err      (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        wb_en       = 1'b0;
        wb_dest     = 3'd0;
        wb_data     = 16'h0000;
        issue_valid = 1'b0;
        issue_wr    = 1'b0;
        issue_dest  = 3'd0;
        src_a_used  = 1'b0;
        src_b_used  = 1'b0;
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i);
            rd_addr_b = 3'(7 - i);
            #1;
            total++;
            if (rd_data_a !== 16'h0000) begin
                bad++;
                $display("FAIL reset_read_a r%0d got=%h exp=0000", i, rd_data_a);
            end
            total++;
            if (rd_data_b !== 16'h0000) begin
                bad++;
                $display("FAIL reset_read_b r%0d got=%h exp=0000", 7 - i, rd_data_b);
            end
        end
        total++;
        if (busy_vec !== 8'h00 || sb_err !== 1'b0 || stall !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got busy=%h err=%b stall=%b exp busy=00 err=0 stall=0",
                     busy_vec, sb_err, stall);
        end
        // Writeback to r0 is dropped and not flagged; no bypass for r0 either.
        tick();
        wb_en = 1'b1; wb_dest = 3'd0; wb_data = 16'hFFFF; rd_addr_a = 3'd0;
        #1;
        total++;
        if (rd_data_a !== 16'h0000) begin
            bad++;
            $display("FAIL r0_no_bypass got=%h exp=0000", rd_data_a);
        end
        tick();
        idle();
        #1;
        total++;
        if (rd_data_a !== 16'h0000 || sb_err !== 1'b0) begin
            bad++;
            $display("FAIL r0_write_ignored got data=%h err=%b exp data=0000 err=0", rd_data_a, sb_err);
        end
    endtask

    task automatic test_bypass();
        tick();
        issue_valid = 1'b1; issue_wr = 1'b1; issue_dest = 3'd3;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL issue_r3 stall got=%b exp=0", stall);
        end
        tick();
        idle();
        #1;
        total++;
        if (busy_vec !== 8'h08) begin
            bad++;
            $display("FAIL busy_r3 got=%h exp=08", busy_vec);
        end
        tick();
        wb_en = 1'b1; wb_dest = 3'd3; wb_data = 16'h1234;
        issue_valid = 1'b1; src_a_used = 1'b1; rd_addr_a = 3'd3;
        #1;
        total++;
        if (stall !== 1'b0 || rd_data_a !== 16'h1234) begin
            bad++;
            $display("FAIL bypass_r3 got stall=%b data=%h exp stall=0 data=1234", stall, rd_data_a);
        end
        tick();
        idle();
        #1;
        total++;
        if (busy_vec !== 8'h00 || rd_data_a !== 16'h1234 || sb_err !== 1'b0) begin
            bad++;
            $display("FAIL after_wb_r3 got busy=%h data=%h err=%b exp busy=00 data=1234 err=0",
                     busy_vec, rd_data_a, sb_err);
        end
    endtask

    task automatic test_raw_stall();
        issue_valid = 1'b1; issue_wr = 1'b1; issue_dest = 3'd5;
        tick();
        idle();
        issue_valid = 1'b1; src_b_used = 1'b1; rd_addr_b = 3'd5;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++;
            if (stall !== 1'b1) begin
                bad++;
                $display("FAIL raw_r5_stall cycle%0d got=%b exp=1", c, stall);
            end
            tick();
        end
        wb_en = 1'b1; wb_dest = 3'd5; wb_data = 16'h0055;
        #1;
        total++;
        if (stall !== 1'b0 || rd_data_b !== 16'h0055) begin
            bad++;
            $display("FAIL raw_r5_release got stall=%b data=%h exp stall=0 data=0055", stall, rd_data_b);
        end
        tick();
        idle();
        #1;
        total++;
        if (busy_vec !== 8'h00 || rd_data_b !== 16'h0055) begin
            bad++;
            $display("FAIL raw_r5_done got busy=%h data=%h exp busy=00 data=0055", busy_vec, rd_data_b);
        end
    endtask

    task automatic test_saturation();
        issue_valid = 1'b1; issue_wr = 1'b1; issue_dest = 3'd2;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (stall !== 1'b0) begin
                bad++;
                $display("FAIL sat_issue%0d stall got=%b exp=0", k, stall);
            end
            tick();
        end
        #1;
        total++;
        if (stall !== 1'b1 || busy_vec !== 8'h04) begin
            bad++;
            $display("FAIL sat_full got stall=%b busy=%h exp stall=1 busy=04", stall, busy_vec);
        end
        wb_en = 1'b1; wb_dest = 3'd2; wb_data = 16'h0222;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL sat_with_wb stall got=%b exp=0", stall);
        end
        tick();
        wb_en = 1'b0;
        #1;
        // Count must still be 3: another issue without writeback stalls.
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL sat_still_full stall got=%b exp=1", stall);
        end
        idle();
        rd_addr_a = 3'd2;
        for (int k = 0; k < 3; k++) begin
            wb_en = 1'b1; wb_dest = 3'd2; wb_data = 16'h2000 + 16'(k);
            tick();
            #1;
            total++;
            if (busy_vec[2] !== (k < 2) || rd_data_a !== 16'h2000 + 16'(k)) begin
                bad++;
                $display("FAIL sat_drain%0d got busy2=%b data=%h exp busy2=%b data=%h",
                         k, busy_vec[2], rd_data_a, (k < 2), 16'h2000 + 16'(k));
            end
        end
        idle();
        tick();
        total++;
        if (busy_vec !== 8'h00 || sb_err !== 1'b0) begin
            bad++;
            $display("FAIL sat_drained got busy=%h err=%b exp busy=00 err=0", busy_vec, sb_err);
        end
    endtask

    task automatic test_back_to_back();
        issue_valid = 1'b1; issue_wr = 1'b1; issue_dest = 3'd4;
        tick();
        // Last write completing while a reader and a new writer of r4 issue.
        wb_en = 1'b1; wb_dest = 3'd4; wb_data = 16'hBEEF;
        src_a_used = 1'b1; rd_addr_a = 3'd4;
        #1;
        total++;
        if (stall !== 1'b0 || rd_data_a !== 16'hBEEF) begin
            bad++;
            $display("FAIL b2b_issue got stall=%b data=%h exp stall=0 data=beef", stall, rd_data_a);
        end
        tick();
        idle();
        #1;
        total++;
        if (busy_vec !== 8'h10) begin
            bad++;
            $display("FAIL b2b_still_busy got=%h exp=10", busy_vec);
        end
        wb_en = 1'b1; wb_dest = 3'd4; wb_data = 16'hCAFE;
        tick();
        idle();
        #1;
        total++;
        if (busy_vec !== 8'h00 || rd_data_a !== 16'hCAFE || sb_err !== 1'b0) begin
            bad++;
            $display("FAIL b2b_done got busy=%h data=%h err=%b exp busy=00 data=cafe err=0",
                     busy_vec, rd_data_a, sb_err);
        end
    endtask

    task automatic test_err_and_reset();
        wb_en = 1'b1; wb_dest = 3'd6; wb_data = 16'h6666;
        tick();
        idle();
        rd_addr_a = 3'd6;
        #1;
        total++;
        if (sb_err !== 1'b1 || rd_data_a !== 16'h6666 || busy_vec !== 8'h00) begin
            bad++;
            $display("FAIL err_r6 got err=%b data=%h busy=%h exp err=1 data=6666 busy=00",
                     sb_err, rd_data_a, busy_vec);
        end
        issue_valid = 1'b1; issue_wr = 1'b1; issue_dest = 3'd1;
        tick();
        idle();
        tick();
        total++;
        if (sb_err !== 1'b1 || busy_vec !== 8'h02) begin
            bad++;
            $display("FAIL err_sticky got err=%b busy=%h exp err=1 busy=02", sb_err, busy_vec);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (sb_err !== 1'b0 || busy_vec !== 8'h00 || rd_data_a !== 16'h0000) begin
            bad++;
            $display("FAIL async_reset got err=%b busy=%h data=%h exp err=0 busy=00 data=0000",
                     sb_err, busy_vec, rd_data_a);
        end
        tick();
        rst = 1'b0;
        // Late writeback for an issue wiped by the reset.
        wb_en = 1'b1; wb_dest = 3'd1; wb_data = 16'h0111;
        tick();
        idle();
        #1;
        total++;
        if (sb_err !== 1'b1 || busy_vec !== 8'h00) begin
            bad++;
            $display("FAIL late_wb_err got err=%b busy=%h exp err=1 busy=00", sb_err, busy_vec);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        rd_addr_a = 3'd0;
        rd_addr_b = 3'd0;
        idle();
        #12;
        rst = 1'b0;
        test_reset();
        test_bypass();
        test_raw_stall();
        test_saturation();
        test_back_to_back();
        test_err_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_reg_file_scoreboard
